pipeline_hazard_controller: RTL and testbench

Central stall/flush sequencer for the 5-stage RV32I pipeline. It detects hazards that the forwarding network cannot cover, namely load-use and ID-stage branch/compare operands not yet available. It freezes the pipeline across I-cache and D-cache misses, tracking single-cycle responses that arrive at different times. It squashes wrong-path fetches on ID-resolved control transfers and drives every pipeline-register load enable. It also keeps stall, bubble and flush performance counters.

---
 rtl/pipeline_hazard_controller_pkg.sv | 47 ++++
 rtl/pipeline_hazard_controller_hazard_detect.sv | 23 ++
 rtl/pipeline_hazard_controller.sv | 124 ++++++++++++
 tb/tb_pipeline_hazard_controller.sv | 360 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipeline_hazard_controller_pkg.sv
// pipeline_hazard_controller_pkg: RV32I control-word types, controller state and shared operand predicates.
//   rv32i_control_word   - decoded per-stage control word (opcode, funct3, register ids, writeback info)
//   hzctl_state_t        - stall sequencer states
//   is_id_consumer()     - instruction needs its operands already in ID (branch, jalr, slt/sltu)
//   writes_operand(p, c) - producer p writes a non-zero register that consumer c reads
package pipeline_hazard_controller_pkg;

    typedef enum logic [6:0] {
        op_lui   = 7'b0110111,
        op_auipc = 7'b0010111,
        op_jal   = 7'b1101111,
        op_jalr  = 7'b1100111,
        op_br    = 7'b1100011,
        op_load  = 7'b0000011,
        op_store = 7'b0100011,
        op_imm   = 7'b0010011,
        op_reg   = 7'b0110011,
        op_csr   = 7'b1110011
    } rv32i_opcode;

    typedef enum logic [2:0] {alu_out, br_en, u_imm, lw, pc_plus4} regfilemux_sel_t;

    localparam logic [2:0] F3_SLT  = 3'b010;
    localparam logic [2:0] F3_SLTU = 3'b011;

    typedef struct packed {
        rv32i_opcode     opcode;
        logic [2:0]      funct3;
        logic [4:0]      rs1_id;
        logic [4:0]      rs2_id;
        logic [4:0]      rd_id;
        logic            load_regfile;
        regfilemux_sel_t regfile_mux_sel;
    } rv32i_control_word;

    typedef enum logic {RUN, MEM_WAIT} hzctl_state_t;

    function automatic logic is_id_consumer(rv32i_control_word c);
        return c.opcode == op_br || c.opcode == op_jalr ||
               ((c.opcode == op_reg || c.opcode == op_imm) && (c.funct3 == F3_SLT || c.funct3 == F3_SLTU));
    endfunction

    function automatic logic writes_operand(rv32i_control_word p, rv32i_control_word c);
        return p.load_regfile && p.rd_id != 5'd0 && (p.rd_id == c.rs1_id || p.rd_id == c.rs2_id);
    endfunction

endpackage

// File: rtl/pipeline_hazard_controller_hazard_detect.sv
// hazard_detect: flags hazards the forwarding network cannot cover.
//   id_ctrl      - control word of the consumer in ID
//   ex_ctrl      - control word of the producer in EX
//   mem_ctrl     - control word of the producer in MEM
//   hazard_stall - hold PC and IF/ID, inject a bubble into ID/EX
module hazard_detect
    import pipeline_hazard_controller_pkg::*;
(
    input  rv32i_control_word id_ctrl,
    input  rv32i_control_word ex_ctrl,
    input  rv32i_control_word mem_ctrl,
    output logic              hazard_stall
);
    logic early, ex_dep, mem_dep, unused_bits;
    assign early   = is_id_consumer(id_ctrl);
    assign ex_dep  = writes_operand(ex_ctrl, id_ctrl);
    assign mem_dep = writes_operand(mem_ctrl, id_ctrl);
    // lui and compare results are known while in EX, so an ID consumer can take them directly
    assign hazard_stall = (ex_dep && ex_ctrl.opcode == op_load) ||
                          (early && ex_dep && ex_ctrl.opcode != op_lui && ex_ctrl.regfile_mux_sel != br_en) ||
                          (early && mem_dep && mem_ctrl.opcode == op_load);
    assign unused_bits = ^{id_ctrl, ex_ctrl, mem_ctrl};
endmodule

// File: rtl/pipeline_hazard_controller.sv
// pipeline_hazard_controller: stall/flush sequencer and pipeline-register enables for the 5-stage RV32I core.
//   clk, rst                                   - clock, synchronous active-high reset
//   id_ex_in_ctrl, id_ex_out_ctrl, ex_mem_out_ctrl - control words in ID, EX, MEM
//   id_xfer_taken                              - ID resolved a taken control transfer
//   imem_read/imem_resp, dmem_read/dmem_write/dmem_resp - memory handshakes (single-cycle responses)
//   load_pc .. load_mem_wb, bubble_id_ex, flush_if_id, if_capture - pipeline controls
//   stall_cycles, bubble_count, flush_count    - saturating performance counters
module pipeline_hazard_controller
    import pipeline_hazard_controller_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  rv32i_control_word id_ex_in_ctrl,
    input  rv32i_control_word id_ex_out_ctrl,
    input  rv32i_control_word ex_mem_out_ctrl,
    input  logic              id_xfer_taken,
    input  logic              imem_read,
    input  logic              imem_resp,
    input  logic              dmem_read,
    input  logic              dmem_write,
    input  logic              dmem_resp,
    output logic              load_pc,
    output logic              load_if_id,
    output logic              load_id_ex,
    output logic              load_ex_mem,
    output logic              load_mem_wb,
    output logic              bubble_id_ex,
    output logic              flush_if_id,
    output logic              if_capture,
    output logic [CNT_W-1:0]  stall_cycles,
    output logic [CNT_W-1:0]  bubble_count,
    output logic [CNT_W-1:0]  flush_count
);
    hzctl_state_t state, state_n;
    logic i_done, d_done, i_done_n, d_done_n, mem_busy, hazard_stall;

    // a response already seen in this wait (flag) satisfies its side until resume
    assign mem_busy = (imem_read & ~imem_resp & ~i_done) |
                      ((dmem_read | dmem_write) & ~dmem_resp & ~d_done);

    hazard_detect u_hazard_detect (
        .id_ctrl      (id_ex_in_ctrl),
        .ex_ctrl      (id_ex_out_ctrl),
        .mem_ctrl     (ex_mem_out_ctrl),
        .hazard_stall (hazard_stall)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= RUN;
            i_done <= 1'b0;
            d_done <= 1'b0;
        end else begin
            state  <= state_n;
            i_done <= i_done_n;
            d_done <= d_done_n;
        end
    end

    always_comb begin
        state_n  = state;
        i_done_n = i_done;
        d_done_n = d_done;
        case (state)
            RUN: if (mem_busy) begin
                state_n  = MEM_WAIT;
                i_done_n = imem_resp;
                d_done_n = dmem_resp;
            end
            MEM_WAIT: if (mem_busy) begin
                i_done_n = i_done | imem_resp;
                d_done_n = d_done | dmem_resp;
            end else begin
                state_n  = RUN;
                i_done_n = 1'b0;
                d_done_n = 1'b0;
            end
            default: state_n = RUN;
        endcase
    end

    always_comb begin
        load_pc      = 1'b0;
        load_if_id   = 1'b0;
        load_id_ex   = 1'b0;
        load_ex_mem  = 1'b0;
        load_mem_wb  = 1'b0;
        bubble_id_ex = 1'b0;
        flush_if_id  = 1'b0;
        if_capture   = 1'b0;
        if (!rst) begin
            if (mem_busy) begin
                if_capture = imem_resp;
            end else if (hazard_stall) begin
                bubble_id_ex = 1'b1;
                load_id_ex   = 1'b1;
                load_ex_mem  = 1'b1;
                load_mem_wb  = 1'b1;
            end else begin
                load_pc     = 1'b1;
                load_if_id  = 1'b1;
                load_id_ex  = 1'b1;
                load_ex_mem = 1'b1;
                load_mem_wb = 1'b1;
                flush_if_id = id_xfer_taken;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cycles <= '0;
            bubble_count <= '0;
            flush_count  <= '0;
        end else begin
            if (mem_busy && !(&stall_cycles)) stall_cycles <= stall_cycles + 1'b1;
            if (bubble_id_ex && !(&bubble_count)) bubble_count <= bubble_count + 1'b1;
            if (flush_if_id && !(&flush_count)) flush_count <= flush_count + 1'b1;
        end
    end

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// tb_pipeline_hazard_controller: directed and randomized checks against a latency-based reference model.
module tb_pipeline_hazard_controller;
    import pipeline_hazard_controller_pkg::*;

    localparam int CW   = 8;
    localparam int CMAX = (1 << CW) - 1;
    localparam logic [7:0] RUN_V  = 8'b11111000;
    localparam logic [7:0] XFER_V = 8'b11111010;
    localparam logic [7:0] HAZ_V  = 8'b00111100;

    logic clk = 1'b0;
    logic rst;
    rv32i_control_word c_id, c_ex, c_mem;
    logic xfer, imem_read, imem_resp, dmem_read, dmem_write, dmem_resp;
    logic load_pc, load_if_id, load_id_ex, load_ex_mem, load_mem_wb, bubble_id_ex, flush_if_id, if_capture;
    logic [CW-1:0] stall_cycles, bubble_count, flush_count;
    logic [7:0] outs;
    int checks = 0, errors = 0;
    int e_stall = 0, e_bub = 0, e_flush = 0;

    rv32i_opcode     ops[8]  = '{op_lui, op_jalr, op_br, op_load, op_store, op_imm, op_reg, op_jal};
    regfilemux_sel_t sels[5] = '{alu_out, br_en, u_imm, lw, pc_plus4};

    always #5 clk = ~clk;

    assign outs = {load_pc, load_if_id, load_id_ex, load_ex_mem, load_mem_wb, bubble_id_ex, flush_if_id, if_capture};

    pipeline_hazard_controller #(.CNT_W(CW)) dut (
        .clk(clk), .rst(rst),
        .id_ex_in_ctrl(c_id), .id_ex_out_ctrl(c_ex), .ex_mem_out_ctrl(c_mem),
        .id_xfer_taken(xfer),
        .imem_read(imem_read), .imem_resp(imem_resp),
        .dmem_read(dmem_read), .dmem_write(dmem_write), .dmem_resp(dmem_resp),
        .load_pc(load_pc), .load_if_id(load_if_id), .load_id_ex(load_id_ex),
        .load_ex_mem(load_ex_mem), .load_mem_wb(load_mem_wb),
        .bubble_id_ex(bubble_id_ex), .flush_if_id(flush_if_id), .if_capture(if_capture),
        .stall_cycles(stall_cycles), .bubble_count(bubble_count), .flush_count(flush_count)
    );

    function automatic rv32i_control_word mk(rv32i_opcode op, logic [2:0] f3, logic [4:0] rd, logic [4:0] rs1,
                                             logic [4:0] rs2, logic wr, regfilemux_sel_t sel);
        rv32i_control_word w;
        w.opcode = op; w.funct3 = f3; w.rd_id = rd; w.rs1_id = rs1; w.rs2_id = rs2;
        w.load_regfile = wr; w.regfile_mux_sel = sel;
        return w;
    endfunction

    function automatic rv32i_control_word nop_w();
        return mk(op_imm, 3'd0, 5'd0, 5'd0, 5'd0, 1'b0, alu_out);
    endfunction

    function automatic rv32i_control_word rand_w();
        return mk(ops[$urandom_range(0, 7)], 3'($urandom_range(0, 7)), 5'($urandom_range(0, 3)),
                  5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                  sels[$urandom_range(0, 4)]);
    endfunction

    // cycles after entering EX before the producer's value can be forwarded
    function automatic int lat(rv32i_control_word p);
        if (p.opcode == op_load) return 2;
        if (p.opcode == op_lui || p.regfile_mux_sel == br_en) return 0;
        return 1;
    endfunction

    // stall when the value is not yet forwardable at the stage where the consumer needs it
    function automatic bit ref_hazard(rv32i_control_word c, rv32i_control_word e, rv32i_control_word m);
        rv32i_control_word p;
        bit early;
        early = c.opcode == op_br || c.opcode == op_jalr ||
                ((c.opcode == op_reg || c.opcode == op_imm) && (c.funct3 == 3'd2 || c.funct3 == 3'd3));
        for (int d = 1; d <= 2; d++) begin
            p = (d == 1) ? e : m;
            if (p.load_regfile && p.rd_id != 0 && (p.rd_id == c.rs1_id || p.rd_id == c.rs2_id))
                if ((early ? d - 1 : d) < lat(p)) return 1;
        end
        return 0;
    endfunction

    function automatic logic [7:0] ref_out(bit stalled, bit hz, bit xf, bit cap);
        if (stalled) return {7'b0, cap};
        if (hz) return HAZ_V;
        return {6'b111110, xf, 1'b0};
    endfunction

    function automatic int sat(int v);
        return v < CMAX ? v + 1 : v;
    endfunction

    task automatic advance(input bit stalled, input logic [7:0] e);
        if (stalled) e_stall = sat(e_stall);
        if (e[2]) e_bub = sat(e_bub);
        if (e[1]) e_flush = sat(e_flush);
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        c_id = nop_w(); c_ex = nop_w(); c_mem = nop_w();
        xfer = 0; imem_read = 0; imem_resp = 0; dmem_read = 0; dmem_write = 0; dmem_resp = 0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1;
        repeat (2) @(posedge clk);
        #1;
        rst = 0;
        e_stall = 0; e_bub = 0; e_flush = 0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1; xfer = 1; imem_read = 1; imem_resp = 1; dmem_read = 1;
        @(negedge clk);
        checks++;
        if (outs !== 8'b0) begin errors++; $display("FAIL reset_outs: got %b expected %b", outs, 8'b0); end
        @(posedge clk);
        #1;
        rst = 0; e_stall = 0; e_bub = 0; e_flush = 0;
        checks++;
        if ({stall_cycles, bubble_count, flush_count} !== '0) begin
            errors++;
            $display("FAIL reset_counters: got %0d %0d %0d expected 0 0 0", stall_cycles, bubble_count, flush_count);
        end
        dmem_resp = 1;
        @(negedge clk);
        checks++;
        if (outs !== XFER_V) begin errors++; $display("FAIL reset_release: got %b expected %b", outs, XFER_V); end
        advance(0, XFER_V);
        checks++;
        if (flush_count !== 8'd1) begin errors++; $display("FAIL reset_flush_cnt: got %0d expected 1", flush_count); end
    endtask

    task automatic test_load_use();
        do_reset();
        c_ex = mk(op_load, 3'd2, 5'd5, 5'd1, 5'd0, 1'b1, lw);
        c_id = mk(op_reg, 3'd0, 5'd6, 5'd5, 5'd1, 1'b1, alu_out);
        @(negedge clk);
        checks++;
        if (outs !== HAZ_V) begin errors++; $display("FAIL load_use_stall: got %b expected %b", outs, HAZ_V); end
        advance(0, HAZ_V);
        c_mem = c_ex; c_ex = nop_w();
        @(negedge clk);
        checks++;
        if (outs !== RUN_V) begin errors++; $display("FAIL load_use_resume: got %b expected %b", outs, RUN_V); end
        advance(0, RUN_V);
        checks++;
        if (bubble_count !== 8'd1) begin errors++; $display("FAIL load_use_bubbles: got %0d expected 1", bubble_count); end
    endtask

    task automatic test_load_branch();
        logic [7:0] exp_tab[4] = '{HAZ_V, HAZ_V, XFER_V, RUN_V};
        do_reset();
        c_ex = mk(op_load, 3'd2, 5'd5, 5'd1, 5'd0, 1'b1, lw);
        c_id = mk(op_br, 3'd0, 5'd0, 5'd5, 5'd0, 1'b0, alu_out);
        for (int t = 0; t < 4; t++) begin
            if (t == 1) begin c_mem = c_ex; c_ex = nop_w(); end
            if (t == 2) begin c_mem = nop_w(); xfer = 1; end
            if (t == 3) begin c_id = nop_w(); xfer = 0; end
            @(negedge clk);
            checks++;
            if (outs !== exp_tab[t]) begin
                errors++; $display("FAIL load_branch_cycle%0d: got %b expected %b", t, outs, exp_tab[t]);
            end
            advance(0, exp_tab[t]);
        end
        checks++;
        if (bubble_count !== 8'd2 || flush_count !== 8'd1) begin
            errors++; $display("FAIL load_branch_counts: got bubbles %0d flushes %0d expected 2 1", bubble_count, flush_count);
        end
    endtask

    task automatic test_alu_lui_branch();
        do_reset();
        c_ex = mk(op_reg, 3'd0, 5'd7, 5'd1, 5'd2, 1'b1, alu_out);
        c_id = mk(op_br, 3'd1, 5'd0, 5'd7, 5'd1, 1'b0, alu_out);
        @(negedge clk);
        checks++;
        if (outs !== HAZ_V) begin errors++; $display("FAIL alu_branch_stall: got %b expected %b", outs, HAZ_V); end
        advance(0, HAZ_V);
        c_mem = c_ex; c_ex = nop_w();
        @(negedge clk);
        checks++;
        if (outs !== RUN_V) begin errors++; $display("FAIL alu_branch_resume: got %b expected %b", outs, RUN_V); end
        advance(0, RUN_V);
        c_mem = nop_w();
        c_ex = mk(op_lui, 3'd0, 5'd8, 5'd0, 5'd0, 1'b1, u_imm);
        c_id = mk(op_br, 3'd1, 5'd0, 5'd8, 5'd0, 1'b0, alu_out);
        @(negedge clk);
        checks++;
        if (outs !== RUN_V) begin errors++; $display("FAIL lui_branch: got %b expected %b", outs, RUN_V); end
        advance(0, RUN_V);
        c_ex = mk(op_reg, 3'd2, 5'd9, 5'd1, 5'd2, 1'b1, br_en);
        c_id = mk(op_imm, 3'd3, 5'd4, 5'd9, 5'd0, 1'b1, br_en);
        @(negedge clk);
        checks++;
        if (outs !== RUN_V) begin errors++; $display("FAIL slt_to_sltiu: got %b expected %b", outs, RUN_V); end
        advance(0, RUN_V);
        checks++;
        if (bubble_count !== 8'd1) begin errors++; $display("FAIL alu_lui_bubbles: got %0d expected 1", bubble_count); end
    endtask

    task automatic test_mem_split();
        int ri_tab[2] = '{6, 2};
        int rd_tab[2] = '{3, 5};
        int r;
        logic [7:0] exp;
        for (int k = 0; k < 2; k++) begin
            do_reset();
            r = ri_tab[k] > rd_tab[k] ? ri_tab[k] : rd_tab[k];
            imem_read = 1; dmem_read = 1; xfer = 1;
            for (int t = 0; t <= r; t++) begin
                imem_resp = (t == ri_tab[k]);
                dmem_resp = (t == rd_tab[k]);
                exp = t < r ? {7'b0, t == ri_tab[k]} : XFER_V;
                @(negedge clk);
                checks++;
                if (outs !== exp) begin
                    errors++; $display("FAIL mem_split%0d_cycle%0d: got %b expected %b", k, t, outs, exp);
                end
                advance(t < r, exp);
            end
            idle_inputs();
            checks++;
            if (stall_cycles !== CW'(r)) begin
                errors++; $display("FAIL mem_split%0d_stall_cnt: got %0d expected %0d", k, stall_cycles, r);
            end
        end
    endtask

    task automatic test_mem_same();
        logic [7:0] exp;
        do_reset();
        imem_read = 1; dmem_write = 1;
        for (int t = 0; t <= 4; t++) begin
            imem_resp = (t == 4); dmem_resp = (t == 4);
            exp = t < 4 ? 8'b0 : RUN_V;
            @(negedge clk);
            checks++;
            if (outs !== exp) begin errors++; $display("FAIL mem_same_cycle%0d: got %b expected %b", t, outs, exp); end
            advance(t < 4, exp);
        end
        imem_resp = 0; dmem_resp = 0;
        @(negedge clk);
        checks++;
        if (outs !== 8'b0) begin errors++; $display("FAIL mem_same_flags_clear: got %b expected %b", outs, 8'b0); end
        advance(1, 8'b0);
        imem_resp = 1; dmem_resp = 1;
        @(negedge clk);
        checks++;
        if (outs !== RUN_V) begin errors++; $display("FAIL mem_same_resume2: got %b expected %b", outs, RUN_V); end
        advance(0, RUN_V);
        idle_inputs();
        checks++;
        if (stall_cycles !== 8'd5) begin errors++; $display("FAIL mem_same_stall_cnt: got %0d expected 5", stall_cycles); end
    endtask

    task automatic test_reset_mid_wait();
        do_reset();
        imem_read = 1; dmem_read = 1;
        for (int t = 0; t < 3; t++) begin
            dmem_resp = (t == 1);
            @(negedge clk);
            checks++;
            if (outs !== 8'b0) begin errors++; $display("FAIL mid_wait_cycle%0d: got %b expected %b", t, outs, 8'b0); end
            advance(1, 8'b0);
        end
        rst = 1; imem_resp = 1; dmem_resp = 0;
        @(negedge clk);
        checks++;
        if (outs !== 8'b0) begin errors++; $display("FAIL mid_wait_rst_outs: got %b expected %b", outs, 8'b0); end
        @(posedge clk);
        #1;
        rst = 0; imem_resp = 0; e_stall = 0; e_bub = 0; e_flush = 0;
        checks++;
        if ({stall_cycles, bubble_count, flush_count} !== '0) begin
            errors++;
            $display("FAIL mid_wait_counters: got %0d %0d %0d expected 0 0 0", stall_cycles, bubble_count, flush_count);
        end
        @(negedge clk);
        checks++;
        if (outs !== 8'b0) begin errors++; $display("FAIL mid_wait_flags_dropped: got %b expected %b", outs, 8'b0); end
        advance(1, 8'b0);
        imem_resp = 1; dmem_resp = 1;
        @(negedge clk);
        checks++;
        if (outs !== RUN_V) begin errors++; $display("FAIL mid_wait_resume: got %b expected %b", outs, RUN_V); end
        advance(0, RUN_V);
        idle_inputs();
        checks++;
        if (stall_cycles !== 8'd1) begin errors++; $display("FAIL mid_wait_stall_cnt: got %0d expected 1", stall_cycles); end
    endtask

    task automatic test_random();
        bit ia, da, stalled;
        int ri, rd, r;
        logic [7:0] exp;
        do_reset();
        for (int s = 0; s < 250; s++) begin
            ia = 1'($urandom_range(0, 1));
            da = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 2) == 0) begin ia = 0; da = 0; end
            ri = ia ? $urandom_range(0, 4) : 0;
            rd = da ? $urandom_range(0, 4) : 0;
            r = ri > rd ? ri : rd;
            dmem_write = da & 1'($urandom_range(0, 1));
            dmem_read = da & ~dmem_write;
            imem_read = ia;
            for (int t = 0; t <= r; t++) begin
                c_id = rand_w(); c_ex = rand_w(); c_mem = rand_w();
                xfer = 1'($urandom_range(0, 1));
                imem_resp = ia && t == ri;
                dmem_resp = da && t == rd;
                stalled = t < r;
                exp = ref_out(stalled, ref_hazard(c_id, c_ex, c_mem), xfer, ia && t == ri);
                @(negedge clk);
                checks++;
                if (outs !== exp) begin
                    errors++; $display("FAIL random_s%0d_t%0d: got %b expected %b", s, t, outs, exp);
                end
                advance(stalled, exp);
            end
        end
        idle_inputs();
        checks++;
        if ({stall_cycles, bubble_count, flush_count} !== {CW'(e_stall), CW'(e_bub), CW'(e_flush)}) begin
            errors++;
            $display("FAIL random_counters: got %0d %0d %0d expected %0d %0d %0d",
                     stall_cycles, bubble_count, flush_count, e_stall, e_bub, e_flush);
        end
    endtask

    task automatic test_saturation();
        do_reset();
        xfer = 1;
        for (int t = 0; t < CMAX + 5; t++) advance(0, XFER_V);
        xfer = 0;
        checks++;
        if (flush_count !== CW'(e_flush) || e_flush != CMAX) begin
            errors++; $display("FAIL flush_saturate: got %0d expected %0d", flush_count, CMAX);
        end
    endtask

    initial begin
        idle_inputs();
        rst = 1;
        test_reset();
        test_load_use();
        test_load_branch();
        test_alu_lui_branch();
        test_mem_split();
        test_mem_same();
        test_reset_mid_wait();
        test_random();
        test_saturation();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
